// File: rtl/pipe_pkg.sv
// Shared types and helpers for the elastic pipeline.
package pipe_pkg;

  // Occupancy of one stage: EMPTY holds nothing, BUSY holds main, FULL holds main+skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

  // Width of a single stage's occupancy report (0..2 items).
  localparam int OCC_W = 2;

  // Bits needed to hold the item count of a whole chain.
  function automatic int count_w(input int depth, input int skid);
    return $clog2(depth * (skid + 1) + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One valid/ready stage of the elastic pipeline.
//
// state | meaning
// EMPTY | no item held, ready for upstream
// BUSY  | one item in main, still ready for upstream
// FULL  | main and skid both hold items, upstream stalled
//
// With SKID=0 the stage is a single valid bit plus data register and the
// ready path is combinational from downstream.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int              WIDTH     = 32,
  parameter int              SKID      = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [OCC_W-1:0] occ
);

  logic in_take;
  logic out_take;

  assign in_take  = in_valid & in_ready;
  assign out_take = out_valid & out_ready;

  if (SKID != 0) begin : g_skid
    stage_state_t     state;
    stage_state_t     state_nx;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    // State register; reset and flush both empty the stage.
    always_ff @(posedge clk) begin
      if (reset || flush) begin
        state <= EMPTY;
      end else begin
        state <= state_nx;
      end
    end

    // Next-state decode from the two handshakes.
    always_comb begin
      state_nx = state;
      unique case (state)
        EMPTY: begin
          if (in_take) state_nx = BUSY;
        end
        BUSY: begin
          if (in_take && !out_take) begin
            state_nx = FULL;
          end else if (out_take && !in_take) begin
            state_nx = EMPTY;
          end
        end
        FULL: begin
          if (out_take) state_nx = BUSY;
        end
        default: state_nx = EMPTY;
      endcase
    end

    // Handshake outputs depend on the state register only, so in_ready
    // never sees out_ready combinationally.
    always_comb begin
      in_ready  = (state != FULL);
      out_valid = (state != EMPTY);
      unique case (state)
        BUSY:    occ = 2'd1;
        FULL:    occ = 2'd2;
        default: occ = 2'd0;
      endcase
    end

    assign out_data = main_q;

    // Payload registers load only on an accepted item, so idle in_data
    // never lands in main; flush leaves them untouched.
    always_ff @(posedge clk) begin
      if (reset) begin
        main_q <= RESET_VAL;
        skid_q <= RESET_VAL;
      end else if (!flush) begin
        unique case (state)
          EMPTY: begin
            if (in_take) main_q <= in_data;
          end
          BUSY: begin
            if (in_take && out_take) begin
              main_q <= in_data;
            end else if (in_take) begin
              skid_q <= in_data;
            end
          end
          FULL: begin
            if (out_take) main_q <= skid_q;
          end
          default: begin
          end
        endcase
      end
    end
  end else begin : g_pass
    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    // Valid bit: set on accept, cleared when the item leaves.
    always_ff @(posedge clk) begin
      if (reset || flush) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= in_take | (valid_q & ~out_take);
      end
    end

    // Data register loads only on accept.
    always_ff @(posedge clk) begin
      if (reset) begin
        data_q <= RESET_VAL;
      end else if (!flush && in_take) begin
        data_q <= in_data;
      end
    end

    // Ready passes straight through when the stage is occupied.
    always_comb begin
      in_ready  = ~valid_q | out_ready;
      out_valid = valid_q;
      occ       = {1'b0, valid_q};
    end

    assign out_data = data_q;
  end

endmodule

// File: rtl/pipe_elastic.sv
// Elastic pipeline: DEPTH chained pipe_stage instances with a total item count.
module pipe_elastic
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 1,
  parameter int               SKID      = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              flush,
  input  logic                              in_valid,
  input  logic [WIDTH-1:0]                  in_data,
  output logic                              in_ready,
  output logic                              out_valid,
  output logic [WIDTH-1:0]                  out_data,
  input  logic                              out_ready,
  output logic [count_w(DEPTH, SKID)-1:0]   count
);

  localparam int CW = count_w(DEPTH, SKID);

  logic [OCC_W-1:0] occ_a [DEPTH];

  // Each generate block owns the wires on its input side; the ready for
  // its output side is read forward from the next block.
  for (genvar i = 0; i < DEPTH; i++) begin : g_st
    logic             s_in_valid;
    logic [WIDTH-1:0] s_in_data;
    logic             s_in_ready;
    logic             s_out_valid;
    logic [WIDTH-1:0] s_out_data;
    logic             s_out_ready;
    logic [OCC_W-1:0] s_occ;

    if (i == 0) begin : g_head
      assign s_in_valid = in_valid;
      assign s_in_data  = in_data;
      assign in_ready   = s_in_ready;
    end else begin : g_link
      assign s_in_valid = g_st[i-1].s_out_valid;
      assign s_in_data  = g_st[i-1].s_out_data;
    end

    if (i == DEPTH - 1) begin : g_tail
      assign s_out_ready = out_ready;
      assign out_valid   = s_out_valid;
      assign out_data    = s_out_data;
    end else begin : g_mid
      assign s_out_ready = g_st[i+1].s_in_ready;
    end

    assign occ_a[i] = s_occ;

    pipe_stage #(
      .WIDTH     (WIDTH),
      .SKID      (SKID),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (s_in_valid),
      .in_data   (s_in_data),
      .in_ready  (s_in_ready),
      .out_valid (s_out_valid),
      .out_data  (s_out_data),
      .out_ready (s_out_ready),
      .occ       (s_occ)
    );
  end

  // Total items held is the sum of stage occupancies.
  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count = count + CW'(occ_a[i]);
    end
  end

endmodule

// File: doc/pipe_elastic.md
# pipe_elastic

Parametrised elastic pipeline register: a chain of DEPTH valid/ready stages carrying a WIDTH-bit payload, with synchronous flush and an optional per-stage skid buffer. It generalises the plain reset and enable flip-flops into a handshaked, stallable, flushable pipeline. It sits between CPU pipeline stages (fetch→decode, decode→execute, memory interface), where backpressure and branch-mispredict flushes must be honoured.

## Interface
- WIDTH, 32: payload width in bits, ≥1.
- DEPTH, 1: number of register stages in the chain, ≥1.
- SKID, 1: 1 = each stage is a 2-entry skid buffer with registered in_ready; 0 = single-entry stage with combinational ready pass-through.
- RESET_VAL, '0: value loaded into all payload registers on reset.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of all held items; has lower priority than reset.
- in_valid  in  1  upstream item present.
- in_data  in  WIDTH  upstream payload.
- in_ready  out  1  stage 0 accepts an item this cycle.
- out_valid  out  1  last stage holds an item.
- out_data  out  WIDTH  last-stage payload.
- out_ready  in  1  downstream accepts.
- count  out  $clog2(DEPTH*(SKID+1)+1)  total items held.

## Operation
- Transfer: an item moves across a boundary on a rising edge when valid and ready are both high on that boundary. Stage i's output feeds stage i+1's input. Stage DEPTH-1 drives the out_* ports.
- SKID=1 per-stage FSM. States: EMPTY (0 items), BUSY (1 item, in main), FULL (main+skid).
  - EMPTY: in accepted → BUSY.
  - BUSY: in accepted and out not taken → FULL (new item into skid). Out taken and no in → EMPTY. Both → BUSY (main ← new item).
  - FULL: out taken → BUSY (main ← skid). In is never accepted in FULL.
  - Stage ready = state≠FULL, taken from a register and independent of out_ready. Stage valid = state≠EMPTY. Stage data = main.
- SKID=0: one valid bit plus one data register per stage. Ready = !valid | downstream ready (combinational chain).
- Order is strictly FIFO. No item is duplicated or dropped, except on flush or reset.
- count = sum of per-stage occupancies. It changes by −1, 0 or +1 per cycle, except on flush or reset.
- flush: all stages → EMPTY, count → 0. An in handshake in the flush cycle is discarded. An out handshake in the flush cycle counts as delivered. Payload registers keep their values.
- reset: same as flush, and all payload registers ← RESET_VAL.
- X on in_data while in_valid=0 must never reach out_data while out_valid=1.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=RESET_VAL, count=0.
- Latency: an item accepted at edge E appears on out_valid/out_data right after edge E+DEPTH−1, with no backpressure.
- Throughput: 1 item/cycle sustained for both SKID values while out_ready=1.
- SKID=1: in_ready falls at most one cycle after backpressure reaches stage 0. The chain absorbs up to 2·DEPTH items with out_ready held low. Once out_ready rises, in_ready recovers one edge after stage 0 leaves FULL.
- SKID=0: capacity DEPTH items. in_ready reflects out_ready in the same cycle when all stages are full.
- Flush or reset mid-stall: the next cycle shows in_ready=1, out_valid=0 and count=0.
- Simultaneous flush and reset: reset wins, and payloads are reset.

## Structure
- Package pipe_pkg holds `stage_state_t` enum {EMPTY, BUSY, FULL} and a count-width function.
- Sub-module pipe_stage implements one stage (WIDTH, SKID). pipe_elastic instantiates it DEPTH times in a generate loop and sums occupancies into count.

## Test plan
- Reset: hold reset 2 cycles with in_valid=1. Required: in_ready=1, out_valid=0, out_data=RESET_VAL, count=0 every cycle after the first edge.
- Streaming, DEPTH=3: send 0x1..0x8 back-to-back with out_ready=1. Required: first out_valid 2 edges after the first accept, 8 consecutive outputs in order, count steady at 3.
- Backpressure, SKID=1, DEPTH=2: out_ready=0, offer 6 items. Required: exactly 4 accepted, then in_ready=0 and count=4. Raising out_ready drains 4 in order.
- Backpressure, SKID=0, DEPTH=2: same stimulus. Required: 2 accepted, and in_ready tracks out_ready in the same cycle.
- Flush while FULL with in_valid=1 and out_ready=1: the item on out is delivered and the in item is dropped. Next cycle: count=0, out_valid=0, in_ready=1.
- Random valid/ready (10k cycles, both SKID values, DEPTH 1–4) against a reference queue model. Required: no loss, no duplication, no reordering, and count matches the model every cycle.
